// File: rtl/axi_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// axi_mem_arbiter_pkg : shared types and AXI constants for the memory arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axi_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
   } arb_rd_state_t;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_ADDR = 2'd1,
      WR_DATA = 2'd2,
      WR_RESP = 2'd3
   } arb_wr_state_t;

   typedef enum logic {
      ARB_IBUS = 1'b0,
      ARB_DBUS = 1'b1
   } arb_master_t;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/axi_mem_arbiter_grant.sv
// ----------------------------------------------------------------------------
// axi_arb_grant : two-way tie breaker; round-robin when AXI_ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed dbus priority.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_arb_grant
   import axi_mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_ibus_i,
   input  logic        req_dbus_i,
   input  arb_master_t last_i,
   input  logic        upd_i,
   output arb_master_t gnt_o
);

`ifdef AXI_ARB_ROUND_ROBIN_EN
   // Pointer holds the master served last; the other one wins a tie.
   arb_master_t ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= ARB_IBUS;
      end else if (upd_i) begin
         ptr_q <= last_i;
      end
   end

   always_comb begin
      gnt_o = ARB_IBUS;
      if (req_ibus_i && req_dbus_i) begin
         gnt_o = (ptr_q == ARB_IBUS) ? ARB_DBUS : ARB_IBUS;
      end else if (req_dbus_i) begin
         gnt_o = ARB_DBUS;
      end
   end
`else
   logic w_unused_rr;
   assign w_unused_rr = &{1'b0, clk, rst, req_ibus_i, last_i, upd_i};

   always_comb begin
      gnt_o = req_dbus_i ? ARB_DBUS : ARB_IBUS;
   end
`endif

endmodule

`default_nettype wire

// File: rtl/axi_mem_arbiter.sv
// ----------------------------------------------------------------------------
// axi_mem_arbiter : ibus/dbus to single AXI4 memory port, independent R/W paths.
// Rev 1.0   Macro: AXI_ARB_ROUND_ROBIN_EN (round-robin tie break)
// ----------------------------------------------------------------------------
`default_nettype none

module axi_mem_arbiter
   import axi_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   // instruction bus
   input  logic [ADDR_WIDTH-1:0]   axi_ibus_araddr_i,
   input  logic [7:0]              axi_ibus_arlen_i,
   input  logic [2:0]              axi_ibus_arsize_i,
   input  logic [1:0]              axi_ibus_arburst_i,
   input  logic                    axi_ibus_arvalid_i,
   output logic                    axi_ibus_arready_o,
   output logic [DATA_WIDTH-1:0]   axi_ibus_rdata_o,
   output logic [1:0]              axi_ibus_rresp_o,
   output logic                    axi_ibus_rvalid_o,
   output logic                    axi_ibus_rlast_o,
   input  logic                    axi_ibus_rready_i,
   input  logic [ADDR_WIDTH-1:0]   axi_ibus_awaddr_i,
   input  logic [7:0]              axi_ibus_awlen_i,
   input  logic [2:0]              axi_ibus_awsize_i,
   input  logic [1:0]              axi_ibus_awburst_i,
   input  logic                    axi_ibus_awvalid_i,
   output logic                    axi_ibus_awready_o,
   input  logic [DATA_WIDTH-1:0]   axi_ibus_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] axi_ibus_wstrb_i,
   input  logic                    axi_ibus_wlast_i,
   input  logic                    axi_ibus_wvalid_i,
   output logic                    axi_ibus_wready_o,
   output logic [1:0]              axi_ibus_bresp_o,
   output logic                    axi_ibus_bvalid_o,
   input  logic                    axi_ibus_bready_i,
   // data bus
   input  logic [ADDR_WIDTH-1:0]   axi_dbus_araddr_i,
   input  logic [7:0]              axi_dbus_arlen_i,
   input  logic [2:0]              axi_dbus_arsize_i,
   input  logic [1:0]              axi_dbus_arburst_i,
   input  logic                    axi_dbus_arvalid_i,
   output logic                    axi_dbus_arready_o,
   output logic [DATA_WIDTH-1:0]   axi_dbus_rdata_o,
   output logic [1:0]              axi_dbus_rresp_o,
   output logic                    axi_dbus_rvalid_o,
   output logic                    axi_dbus_rlast_o,
   input  logic                    axi_dbus_rready_i,
   input  logic [ADDR_WIDTH-1:0]   axi_dbus_awaddr_i,
   input  logic [7:0]              axi_dbus_awlen_i,
   input  logic [2:0]              axi_dbus_awsize_i,
   input  logic [1:0]              axi_dbus_awburst_i,
   input  logic                    axi_dbus_awvalid_i,
   output logic                    axi_dbus_awready_o,
   input  logic [DATA_WIDTH-1:0]   axi_dbus_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] axi_dbus_wstrb_i,
   input  logic                    axi_dbus_wlast_i,
   input  logic                    axi_dbus_wvalid_i,
   output logic                    axi_dbus_wready_o,
   output logic [1:0]              axi_dbus_bresp_o,
   output logic                    axi_dbus_bvalid_o,
   input  logic                    axi_dbus_bready_i,
   // memory port
   output logic [ADDR_WIDTH-1:0]   axi_mem_araddr_o,
   output logic [7:0]              axi_mem_arlen_o,
   output logic [2:0]              axi_mem_arsize_o,
   output logic [1:0]              axi_mem_arburst_o,
   output logic                    axi_mem_arvalid_o,
   input  logic                    axi_mem_arready_i,
   input  logic [DATA_WIDTH-1:0]   axi_mem_rdata_i,
   input  logic [1:0]              axi_mem_rresp_i,
   input  logic                    axi_mem_rvalid_i,
   input  logic                    axi_mem_rlast_i,
   output logic                    axi_mem_rready_o,
   output logic [ADDR_WIDTH-1:0]   axi_mem_awaddr_o,
   output logic [7:0]              axi_mem_awlen_o,
   output logic [2:0]              axi_mem_awsize_o,
   output logic [1:0]              axi_mem_awburst_o,
   output logic                    axi_mem_awvalid_o,
   input  logic                    axi_mem_awready_i,
   output logic [DATA_WIDTH-1:0]   axi_mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] axi_mem_wstrb_o,
   output logic                    axi_mem_wlast_o,
   output logic                    axi_mem_wvalid_o,
   input  logic                    axi_mem_wready_i,
   input  logic [1:0]              axi_mem_bresp_i,
   input  logic                    axi_mem_bvalid_i,
   output logic                    axi_mem_bready_o
);

   arb_rd_state_t rd_state_q, rd_state_d;
   arb_wr_state_t wr_state_q, wr_state_d;
   arb_master_t   rd_gnt_q, rd_gnt_d, w_rd_arb;
   arb_master_t   wr_gnt_q, wr_gnt_d, w_wr_arb;
   logic          w_rd_done, w_wr_done;
   logic          w_rd_dbus, w_wr_dbus;
   logic          w_sel_arvalid, w_sel_rready, w_sel_awvalid, w_sel_wvalid, w_sel_bready;

   assign w_rd_dbus = (rd_gnt_q == ARB_DBUS);
   assign w_wr_dbus = (wr_gnt_q == ARB_DBUS);

   axi_arb_grant u_rd_grant (
      .clk        (clk),
      .rst        (rst),
      .req_ibus_i (axi_ibus_arvalid_i),
      .req_dbus_i (axi_dbus_arvalid_i),
      .last_i     (rd_gnt_q),
      .upd_i      (w_rd_done),
      .gnt_o      (w_rd_arb)
   );

   axi_arb_grant u_wr_grant (
      .clk        (clk),
      .rst        (rst),
      .req_ibus_i (axi_ibus_awvalid_i),
      .req_dbus_i (axi_dbus_awvalid_i),
      .last_i     (wr_gnt_q),
      .upd_i      (w_wr_done),
      .gnt_o      (w_wr_arb)
   );

   // Payloads follow the held grant; only the handshake signals are gated by state.
   assign axi_mem_araddr_o  = w_rd_dbus ? axi_dbus_araddr_i  : axi_ibus_araddr_i;
   assign axi_mem_arlen_o   = w_rd_dbus ? axi_dbus_arlen_i   : axi_ibus_arlen_i;
   assign axi_mem_arsize_o  = w_rd_dbus ? axi_dbus_arsize_i  : axi_ibus_arsize_i;
   assign axi_mem_arburst_o = w_rd_dbus ? axi_dbus_arburst_i : axi_ibus_arburst_i;
   assign axi_mem_awaddr_o  = w_wr_dbus ? axi_dbus_awaddr_i  : axi_ibus_awaddr_i;
   assign axi_mem_awlen_o   = w_wr_dbus ? axi_dbus_awlen_i   : axi_ibus_awlen_i;
   assign axi_mem_awsize_o  = w_wr_dbus ? axi_dbus_awsize_i  : axi_ibus_awsize_i;
   assign axi_mem_awburst_o = w_wr_dbus ? axi_dbus_awburst_i : axi_ibus_awburst_i;
   assign axi_mem_wdata_o   = w_wr_dbus ? axi_dbus_wdata_i   : axi_ibus_wdata_i;
   assign axi_mem_wstrb_o   = w_wr_dbus ? axi_dbus_wstrb_i   : axi_ibus_wstrb_i;
   assign axi_mem_wlast_o   = w_wr_dbus ? axi_dbus_wlast_i   : axi_ibus_wlast_i;

   assign axi_ibus_rdata_o  = axi_mem_rdata_i;
   assign axi_dbus_rdata_o  = axi_mem_rdata_i;
   assign axi_ibus_rresp_o  = axi_mem_rresp_i;
   assign axi_dbus_rresp_o  = axi_mem_rresp_i;
   assign axi_ibus_rlast_o  = axi_mem_rlast_i;
   assign axi_dbus_rlast_o  = axi_mem_rlast_i;
   assign axi_ibus_bresp_o  = axi_mem_bresp_i;
   assign axi_dbus_bresp_o  = axi_mem_bresp_i;

   assign w_sel_arvalid = w_rd_dbus ? axi_dbus_arvalid_i : axi_ibus_arvalid_i;
   assign w_sel_rready  = w_rd_dbus ? axi_dbus_rready_i  : axi_ibus_rready_i;
   assign w_sel_awvalid = w_wr_dbus ? axi_dbus_awvalid_i : axi_ibus_awvalid_i;
   assign w_sel_wvalid  = w_wr_dbus ? axi_dbus_wvalid_i  : axi_ibus_wvalid_i;
   assign w_sel_bready  = w_wr_dbus ? axi_dbus_bready_i  : axi_ibus_bready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state_q <= RD_IDLE;
         wr_state_q <= WR_IDLE;
         rd_gnt_q   <= ARB_IBUS;
         wr_gnt_q   <= ARB_IBUS;
      end else begin
         rd_state_q <= rd_state_d;
         wr_state_q <= wr_state_d;
         rd_gnt_q   <= rd_gnt_d;
         wr_gnt_q   <= wr_gnt_d;
      end
   end

   always_comb begin
      rd_state_d         = rd_state_q;
      rd_gnt_d           = rd_gnt_q;
      w_rd_done          = 1'b0;
      axi_mem_arvalid_o  = 1'b0;
      axi_mem_rready_o   = 1'b0;
      axi_ibus_arready_o = 1'b0;
      axi_dbus_arready_o = 1'b0;
      axi_ibus_rvalid_o  = 1'b0;
      axi_dbus_rvalid_o  = 1'b0;
      case (rd_state_q)
         RD_IDLE: begin
            if (axi_ibus_arvalid_i || axi_dbus_arvalid_i) begin
               rd_gnt_d   = w_rd_arb;
               rd_state_d = RD_ADDR;
            end
         end
         RD_ADDR: begin
            axi_mem_arvalid_o  = w_sel_arvalid;
            axi_ibus_arready_o = !w_rd_dbus && axi_mem_arready_i;
            axi_dbus_arready_o = w_rd_dbus && axi_mem_arready_i;
            if (w_sel_arvalid && axi_mem_arready_i) begin
               rd_state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            axi_mem_rready_o  = w_sel_rready;
            axi_ibus_rvalid_o = !w_rd_dbus && axi_mem_rvalid_i;
            axi_dbus_rvalid_o = w_rd_dbus && axi_mem_rvalid_i;
            if (axi_mem_rvalid_i && w_sel_rready && axi_mem_rlast_i) begin
               rd_state_d = RD_IDLE;
               w_rd_done  = 1'b1;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      wr_state_d         = wr_state_q;
      wr_gnt_d           = wr_gnt_q;
      w_wr_done          = 1'b0;
      axi_mem_awvalid_o  = 1'b0;
      axi_mem_wvalid_o   = 1'b0;
      axi_mem_bready_o   = 1'b0;
      axi_ibus_awready_o = 1'b0;
      axi_dbus_awready_o = 1'b0;
      axi_ibus_wready_o  = 1'b0;
      axi_dbus_wready_o  = 1'b0;
      axi_ibus_bvalid_o  = 1'b0;
      axi_dbus_bvalid_o  = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (axi_ibus_awvalid_i || axi_dbus_awvalid_i) begin
               wr_gnt_d   = w_wr_arb;
               wr_state_d = WR_ADDR;
            end
         end
         WR_ADDR: begin
            axi_mem_awvalid_o  = w_sel_awvalid;
            axi_ibus_awready_o = !w_wr_dbus && axi_mem_awready_i;
            axi_dbus_awready_o = w_wr_dbus && axi_mem_awready_i;
            if (w_sel_awvalid && axi_mem_awready_i) begin
               wr_state_d = WR_DATA;
            end
         end
         WR_DATA: begin
            axi_mem_wvalid_o  = w_sel_wvalid;
            axi_ibus_wready_o = !w_wr_dbus && axi_mem_wready_i;
            axi_dbus_wready_o = w_wr_dbus && axi_mem_wready_i;
            if (w_sel_wvalid && axi_mem_wready_i && axi_mem_wlast_o) begin
               wr_state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            axi_mem_bready_o  = w_sel_bready;
            axi_ibus_bvalid_o = !w_wr_dbus && axi_mem_bvalid_i;
            axi_dbus_bvalid_o = w_wr_dbus && axi_mem_bvalid_i;
            if (axi_mem_bvalid_i && w_sel_bready) begin
               wr_state_d = WR_IDLE;
               w_wr_done  = 1'b1;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_mem_arbiter : directed bench for axi_mem_arbiter; honours
// AXI_ARB_ROUND_ROBIN_EN for the tie expectations.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axi_mem_arbiter;
   import axi_mem_arbiter_pkg::*;

   logic clk, rst;
   logic [31:0] ibus_araddr, dbus_araddr, ibus_awaddr, dbus_awaddr;
   logic [7:0]  ibus_arlen, dbus_arlen, ibus_awlen, dbus_awlen;
   logic [2:0]  ibus_arsize, dbus_arsize, ibus_awsize, dbus_awsize;
   logic [1:0]  ibus_arburst, dbus_arburst, ibus_awburst, dbus_awburst;
   logic        ibus_arvalid, dbus_arvalid, ibus_arready, dbus_arready;
   logic [31:0] ibus_rdata, dbus_rdata;
   logic [1:0]  ibus_rresp, dbus_rresp, ibus_bresp, dbus_bresp;
   logic        ibus_rvalid, dbus_rvalid, ibus_rlast, dbus_rlast, ibus_rready, dbus_rready;
   logic        ibus_awvalid, dbus_awvalid, ibus_awready, dbus_awready;
   logic [31:0] ibus_wdata, dbus_wdata;
   logic [3:0]  ibus_wstrb, dbus_wstrb;
   logic        ibus_wlast, dbus_wlast, ibus_wvalid, dbus_wvalid, ibus_wready, dbus_wready;
   logic        ibus_bvalid, dbus_bvalid, ibus_bready, dbus_bready;
   logic [31:0] mem_araddr, mem_awaddr, mem_rdata, mem_wdata;
   logic [7:0]  mem_arlen, mem_awlen;
   logic [2:0]  mem_arsize, mem_awsize;
   logic [1:0]  mem_arburst, mem_awburst, mem_rresp, mem_bresp;
   logic        mem_arvalid, mem_arready, mem_rvalid, mem_rlast, mem_rready;
   logic        mem_awvalid, mem_awready, mem_wlast, mem_wvalid, mem_wready;
   logic [3:0]  mem_wstrb;
   logic        mem_bvalid, mem_bready;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_cnt = 0;
   int ar_hs = -1;
   int aw_hs = -2;

   axi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .axi_ibus_araddr_i(ibus_araddr), .axi_ibus_arlen_i(ibus_arlen), .axi_ibus_arsize_i(ibus_arsize),
      .axi_ibus_arburst_i(ibus_arburst), .axi_ibus_arvalid_i(ibus_arvalid), .axi_ibus_arready_o(ibus_arready),
      .axi_ibus_rdata_o(ibus_rdata), .axi_ibus_rresp_o(ibus_rresp), .axi_ibus_rvalid_o(ibus_rvalid),
      .axi_ibus_rlast_o(ibus_rlast), .axi_ibus_rready_i(ibus_rready),
      .axi_ibus_awaddr_i(ibus_awaddr), .axi_ibus_awlen_i(ibus_awlen), .axi_ibus_awsize_i(ibus_awsize),
      .axi_ibus_awburst_i(ibus_awburst), .axi_ibus_awvalid_i(ibus_awvalid), .axi_ibus_awready_o(ibus_awready),
      .axi_ibus_wdata_i(ibus_wdata), .axi_ibus_wstrb_i(ibus_wstrb), .axi_ibus_wlast_i(ibus_wlast),
      .axi_ibus_wvalid_i(ibus_wvalid), .axi_ibus_wready_o(ibus_wready),
      .axi_ibus_bresp_o(ibus_bresp), .axi_ibus_bvalid_o(ibus_bvalid), .axi_ibus_bready_i(ibus_bready),
      .axi_dbus_araddr_i(dbus_araddr), .axi_dbus_arlen_i(dbus_arlen), .axi_dbus_arsize_i(dbus_arsize),
      .axi_dbus_arburst_i(dbus_arburst), .axi_dbus_arvalid_i(dbus_arvalid), .axi_dbus_arready_o(dbus_arready),
      .axi_dbus_rdata_o(dbus_rdata), .axi_dbus_rresp_o(dbus_rresp), .axi_dbus_rvalid_o(dbus_rvalid),
      .axi_dbus_rlast_o(dbus_rlast), .axi_dbus_rready_i(dbus_rready),
      .axi_dbus_awaddr_i(dbus_awaddr), .axi_dbus_awlen_i(dbus_awlen), .axi_dbus_awsize_i(dbus_awsize),
      .axi_dbus_awburst_i(dbus_awburst), .axi_dbus_awvalid_i(dbus_awvalid), .axi_dbus_awready_o(dbus_awready),
      .axi_dbus_wdata_i(dbus_wdata), .axi_dbus_wstrb_i(dbus_wstrb), .axi_dbus_wlast_i(dbus_wlast),
      .axi_dbus_wvalid_i(dbus_wvalid), .axi_dbus_wready_o(dbus_wready),
      .axi_dbus_bresp_o(dbus_bresp), .axi_dbus_bvalid_o(dbus_bvalid), .axi_dbus_bready_i(dbus_bready),
      .axi_mem_araddr_o(mem_araddr), .axi_mem_arlen_o(mem_arlen), .axi_mem_arsize_o(mem_arsize),
      .axi_mem_arburst_o(mem_arburst), .axi_mem_arvalid_o(mem_arvalid), .axi_mem_arready_i(mem_arready),
      .axi_mem_rdata_i(mem_rdata), .axi_mem_rresp_i(mem_rresp), .axi_mem_rvalid_i(mem_rvalid),
      .axi_mem_rlast_i(mem_rlast), .axi_mem_rready_o(mem_rready),
      .axi_mem_awaddr_o(mem_awaddr), .axi_mem_awlen_o(mem_awlen), .axi_mem_awsize_o(mem_awsize),
      .axi_mem_awburst_o(mem_awburst), .axi_mem_awvalid_o(mem_awvalid), .axi_mem_awready_i(mem_awready),
      .axi_mem_wdata_o(mem_wdata), .axi_mem_wstrb_o(mem_wstrb), .axi_mem_wlast_o(mem_wlast),
      .axi_mem_wvalid_o(mem_wvalid), .axi_mem_wready_i(mem_wready),
      .axi_mem_bresp_i(mem_bresp), .axi_mem_bvalid_i(mem_bvalid), .axi_mem_bready_o(mem_bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [14:0] all_vr();
      return {mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready,
              ibus_arready, ibus_rvalid, ibus_awready, ibus_wready, ibus_bvalid,
              dbus_arready, dbus_rvalid, dbus_awready, dbus_wready, dbus_bvalid};
   endfunction

   function automatic logic arready_of(input logic m); return m ? dbus_arready : ibus_arready; endfunction
   function automatic logic rvalid_of (input logic m); return m ? dbus_rvalid  : ibus_rvalid;  endfunction
   function automatic logic awready_of(input logic m); return m ? dbus_awready : ibus_awready; endfunction
   function automatic logic wready_of (input logic m); return m ? dbus_wready  : ibus_wready;  endfunction
   function automatic logic bvalid_of (input logic m); return m ? dbus_bvalid  : ibus_bvalid;  endfunction
   function automatic logic [31:0] rdata_of(input logic m); return m ? dbus_rdata : ibus_rdata; endfunction
   function automatic logic [1:0]  rresp_of(input logic m); return m ? dbus_rresp : ibus_rresp; endfunction
   function automatic logic        rlast_of(input logic m); return m ? dbus_rlast : ibus_rlast; endfunction
   function automatic logic [1:0]  bresp_of(input logic m); return m ? dbus_bresp : ibus_bresp; endfunction

   task automatic set_ar(input logic m, input logic v, input logic [31:0] a, input logic [7:0] len);
      if (m) begin
         dbus_arvalid = v; dbus_araddr = a; dbus_arlen = len; dbus_arsize = 3'd2; dbus_arburst = AXI_BURST_INCR;
      end else begin
         ibus_arvalid = v; ibus_araddr = a; ibus_arlen = len; ibus_arsize = 3'd2; ibus_arburst = AXI_BURST_INCR;
      end
   endtask

   task automatic set_aw(input logic m, input logic v, input logic [31:0] a, input logic [7:0] len);
      if (m) begin
         dbus_awvalid = v; dbus_awaddr = a; dbus_awlen = len; dbus_awsize = 3'd2; dbus_awburst = AXI_BURST_INCR;
      end else begin
         ibus_awvalid = v; ibus_awaddr = a; ibus_awlen = len; ibus_awsize = 3'd2; ibus_awburst = AXI_BURST_INCR;
      end
   endtask

   task automatic set_w(input logic m, input logic v, input logic [31:0] d, input logic last);
      if (m) begin
         dbus_wvalid = v; dbus_wdata = d; dbus_wstrb = 4'hF; dbus_wlast = last;
      end else begin
         ibus_wvalid = v; ibus_wdata = d; ibus_wstrb = 4'hF; ibus_wlast = last;
      end
   endtask

   task automatic set_rb(input logic m, input logic rr, input logic br);
      if (m) begin dbus_rready = rr; dbus_bready = br; end
      else   begin ibus_rready = rr; ibus_bready = br; end
   endtask

   // Entered in an IDLE cycle; leaves the read path in its next IDLE cycle.
   task automatic rd_burst(input logic m, input logic [31:0] addr, input int nb,
                           input int stall, input int err, input logic [31:0] base);
      set_ar(m, 1'b1, addr, 8'(nb - 1));
      mem_arready = 1'b0;
      #1 check_eq("rd_idle_arvalid", mem_arvalid, 0);
      cyc();
      for (int k = 0; k < stall; k++) begin
         check_eq("rd_stall_arvalid", mem_arvalid, 1);
         check_eq("rd_stall_arready", arready_of(m), 0);
         cyc();
      end
      mem_arready = 1'b1;
      #1;
      check_eq("rd_arvalid", mem_arvalid, 1);
      check_eq("rd_araddr", mem_araddr, addr);
      check_eq("rd_arlen", mem_arlen, nb - 1);
      check_eq("rd_arready_gnt", arready_of(m), 1);
      check_eq("rd_arready_other", arready_of(!m), 0);
      ar_hs = cyc_cnt;
      cyc();
      set_ar(m, 1'b0, addr, 8'(nb - 1));
      mem_arready = 1'b0;
      set_rb(m, 1'b1, 1'b0);
      for (int i = 0; i < nb; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = base + 32'(i);
         mem_rresp  = (i == err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         mem_rlast  = (i == nb - 1);
         #1;
         check_eq("rd_rvalid_gnt", rvalid_of(m), 1);
         check_eq("rd_rvalid_other", rvalid_of(!m), 0);
         check_eq("rd_rdata", rdata_of(m), base + 32'(i));
         check_eq("rd_rresp", rresp_of(m), (i == err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
         check_eq("rd_rlast", rlast_of(m), (i == nb - 1));
         check_eq("rd_mem_rready", mem_rready, 1);
         cyc();
      end
      #1 check_eq("rd_done_rvalid", rvalid_of(m), 0);
      mem_rvalid = 1'b0;
      mem_rlast  = 1'b0;
      set_rb(m, 1'b0, 1'b0);
   endtask

   task automatic wr_burst(input logic m, input logic [31:0] addr, input int nb,
                           input bit tog, input logic [31:0] base);
      int   beat  = 0;
      int   guard = 0;
      logic rdy;
      set_aw(m, 1'b1, addr, 8'(nb - 1));
      set_w(m, 1'b1, base, nb == 1);
      mem_awready = 1'b1;
      mem_wready  = 1'b1;
      #1;
      check_eq("wr_idle_awvalid", mem_awvalid, 0);
      check_eq("wr_idle_wvalid", mem_wvalid, 0);
      cyc();
      #1;
      check_eq("wr_awvalid", mem_awvalid, 1);
      check_eq("wr_awaddr", mem_awaddr, addr);
      check_eq("wr_awready_gnt", awready_of(m), 1);
      check_eq("wr_awready_other", awready_of(!m), 0);
      check_eq("wr_w_held", mem_wvalid, 0);
      check_eq("wr_wready_held", wready_of(m), 0);
      aw_hs = cyc_cnt;
      cyc();
      set_aw(m, 1'b0, addr, 8'(nb - 1));
      mem_awready = 1'b0;
      while (beat < nb && guard < 4 * nb) begin
         rdy = tog ? guard[0] : 1'b1;
         mem_wready = rdy;
         set_w(m, 1'b1, base + 32'(beat), beat == nb - 1);
         #1;
         check_eq("wr_wvalid", mem_wvalid, 1);
         check_eq("wr_wdata", mem_wdata, base + 32'(beat));
         check_eq("wr_wstrb", mem_wstrb, 4'hF);
         check_eq("wr_wlast", mem_wlast, beat == nb - 1);
         check_eq("wr_wready_gnt", wready_of(m), rdy);
         check_eq("wr_wready_other", wready_of(!m), 0);
         if (rdy) beat++;
         guard++;
         cyc();
      end
      check_eq("wr_beats", beat, nb);
      set_w(m, 1'b0, 32'h0, 1'b0);
      mem_wready = 1'b0;
      mem_bvalid = 1'b1;
      mem_bresp  = AXI_RESP_OKAY;
      set_rb(m, 1'b0, 1'b1);
      #1;
      check_eq("wr_bvalid_gnt", bvalid_of(m), 1);
      check_eq("wr_bvalid_other", bvalid_of(!m), 0);
      check_eq("wr_bresp", bresp_of(m), AXI_RESP_OKAY);
      check_eq("wr_mem_bready", mem_bready, 1);
      cyc();
      #1 check_eq("wr_done_bvalid", bvalid_of(m), 0);
      mem_bvalid = 1'b0;
      set_rb(m, 1'b0, 1'b0);
   endtask

   task automatic clear_inputs();
      set_ar(1'b0, 1'b0, 32'h0, 8'h0); set_ar(1'b1, 1'b0, 32'h0, 8'h0);
      set_aw(1'b0, 1'b0, 32'h0, 8'h0); set_aw(1'b1, 1'b0, 32'h0, 8'h0);
      set_w(1'b0, 1'b0, 32'h0, 1'b0);  set_w(1'b1, 1'b0, 32'h0, 1'b0);
      set_rb(1'b0, 1'b0, 1'b0);        set_rb(1'b1, 1'b0, 1'b0);
      mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rresp = AXI_RESP_OKAY;
      mem_rlast = 1'b0; mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0;
      mem_bresp = AXI_RESP_OKAY;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      // Reset must hold every handshake output low even with traffic offered.
      ibus_arvalid = 1'b1; dbus_awvalid = 1'b1; ibus_wvalid = 1'b1; ibus_rready = 1'b1;
      ibus_bready = 1'b1; mem_arready = 1'b1; mem_awready = 1'b1; mem_wready = 1'b1;
      mem_rvalid = 1'b1; mem_bvalid = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_eq("reset_outputs", all_vr(), 0);
      clear_inputs();
      rst = 1'b0;
      cyc();

      // Single ibus read, 4 beats 0xA0..0xA3
      rd_burst(ARB_IBUS, 32'h1000, 4, 0, -1, 32'hA0);

      // Read tie twice, then serve the remaining requester
      set_ar(ARB_IBUS, 1'b1, 32'h6000, 8'd1);
      rd_burst(ARB_DBUS, 32'h7000, 2, 0, -1, 32'h70);
`ifdef AXI_ARB_ROUND_ROBIN_EN
      set_ar(ARB_DBUS, 1'b1, 32'h7100, 8'd1);
      rd_burst(ARB_IBUS, 32'h6000, 2, 0, -1, 32'h60);
      rd_burst(ARB_DBUS, 32'h7100, 2, 0, -1, 32'h71);
`else
      rd_burst(ARB_DBUS, 32'h7100, 2, 0, -1, 32'h71);
      rd_burst(ARB_IBUS, 32'h6000, 2, 0, -1, 32'h60);
`endif

      // dbus write overlapping an ibus read
      fork
         rd_burst(ARB_IBUS, 32'h3000, 4, 0, -1, 32'hC0);
         wr_burst(ARB_DBUS, 32'h2000, 4, 1'b0, 32'hD0);
      join
      check_eq("conc_hs_same_cycle", ar_hs, aw_hs);

      // Backpressure: 5-cycle AR stall, toggling wready
      rd_burst(ARB_DBUS, 32'h8000, 2, 5, -1, 32'h80);
      wr_burst(ARB_IBUS, 32'h9000, 4, 1'b1, 32'h90);

      // SLVERR on beat 2 of 4
      rd_burst(ARB_IBUS, 32'hA000, 4, 0, 1, 32'hB0);

      // Reset during beat 2 of a dbus write
      set_aw(ARB_DBUS, 1'b1, 32'h4000, 8'd3);
      mem_awready = 1'b1;
      cyc();
      cyc();
      set_aw(ARB_DBUS, 1'b0, 32'h4000, 8'd3);
      mem_awready = 1'b0;
      set_w(ARB_DBUS, 1'b1, 32'h11, 1'b0);
      mem_wready = 1'b1;
      cyc();
      set_w(ARB_DBUS, 1'b1, 32'h22, 1'b0);
      #1 check_eq("rst_pre_wvalid", mem_wvalid, 1);
      rst = 1'b1;
      #1 check_eq("rst_mid_outputs", all_vr(), 0);
      cyc();
      rst = 1'b0;
      clear_inputs();
      rd_burst(ARB_IBUS, 32'h5000, 2, 0, -1, 32'h50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
